cart_debug_dma: RTL and testbench

- Bus initiator for the USB debug path.
- Triggered by the control register block's debug-DMA start pulse, it pops bytes from the USB RX FIFO and packs them big-endian into 32-bit words. It then writes those words into a cart memory bank over the internal request/write/busy bus.
- It is the initiator end of the same bus that the register-file responders answer on. It reports progress back through o_busy.

---
 rtl/cart_pkg.sv | 21 ++
 rtl/cart_debug_dma_if.sv | 31 +++
 rtl/cart_debug_dma.sv | 132 +++++++++++++
 tb/tb_cart_debug_dma.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_pkg.sv
// Shared definitions for the cart debug-DMA slice.
// Provides the DMA state encoding, the bus bank select constants and the
// default widths used by the DMA and its bus interface.
package cart_pkg;

  localparam int unsigned LENGTH_WIDTH  = 20;
  localparam int unsigned ADDRESS_WIDTH = 24;

  localparam logic [3:0] BANK_CART  = 4'd0;
  localparam logic [3:0] BANK_SDRAM = 4'd1;
  localparam logic [3:0] BANK_FLASH = 4'd2;
  localparam logic [3:0] BANK_BRAM  = 4'd3;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CAPTURE,
    WRITE
  } state_t;

endpackage

// File: rtl/cart_debug_dma_if.sv
// Bus bundle for the debug DMA: the USB RX FIFO pop side and the internal
// request/write/busy bus towards the cart memory banks.
//   master : the DMA (pops the FIFO, initiates bus writes)
//   slave  : the FIFO + bus responder side
// Signals: rx_empty, rx_read, rx_data[7:0], request, write, busy,
//          bank[3:0], address[ADDRESS_WIDTH-1:0], data[31:0]
interface cart_debug_dma_if #(
  parameter int unsigned ADDRESS_WIDTH = cart_pkg::ADDRESS_WIDTH
) ();

  logic                     rx_empty;
  logic                     rx_read;
  logic [7:0]               rx_data;
  logic                     request;
  logic                     write;
  logic                     busy;
  logic [3:0]               bank;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [31:0]              data;

  modport master (
    input  rx_empty, rx_data, busy,
    output rx_read, request, write, bank, address, data
  );

  modport slave (
    output rx_empty, rx_data, busy,
    input  rx_read, request, write, bank, address, data
  );

endinterface

// File: rtl/cart_debug_dma.sv
// USB debug-path DMA initiator. On an accepted start pulse it pops bytes
// from the USB RX FIFO, packs them big-endian into 32-bit words and writes
// the words to consecutive word addresses of the selected cart bank.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_start, i_stop     start pulse / abort request
//   i_bank, i_address,  transfer parameters, sampled on accepted start
//   i_length
//   o_busy              transfer in progress
//   bus (master)        FIFO pop side and request/write/busy bus
module cart_debug_dma
  import cart_pkg::*;
#(
  parameter int unsigned LENGTH_WIDTH  = cart_pkg::LENGTH_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = cart_pkg::ADDRESS_WIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic [3:0]               i_bank,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic [LENGTH_WIDTH-1:0]  i_length,
  output logic                     o_busy,
  cart_debug_dma_if.master         bus
);

  state_t                   state, state_next;
  logic [3:0]               bank_r;
  logic [ADDRESS_WIDTH-1:0] address_r;
  logic [LENGTH_WIDTH-1:0]  remaining;
  logic [1:0]               lane;
  logic [31:0]              word;

  logic rx_read;
  logic request;
  logic load;
  logic capture;
  logic accept;

  always_comb begin
    state_next = state;
    rx_read    = 1'b0;
    request    = 1'b0;
    load       = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (i_start && (i_length != '0)) begin
          load       = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (!bus.rx_empty) begin
          rx_read    = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        capture = 1'b1;
        if ((lane == 2'd3) || (remaining == LENGTH_WIDTH'(1))) begin
          state_next = WRITE;
        end else begin
          state_next = FETCH;
        end
      end
      WRITE: begin
        request = 1'b1;
        if (!bus.busy) begin
          accept     = 1'b1;
          state_next = (remaining != '0) ? FETCH : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Abort wins over everything but reset. A write already presented on
    // the bus may still be accepted this cycle, so request/accept survive.
    if (i_stop) begin
      state_next = IDLE;
      load       = 1'b0;
      capture    = 1'b0;
      rx_read    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      bank_r    <= '0;
      address_r <= '0;
      remaining <= '0;
      lane      <= '0;
      word      <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        bank_r    <= i_bank;
        address_r <= i_address;
        remaining <= i_length;
        lane      <= '0;
        word      <= '0;
      end
      if (capture) begin
        // Lane 0 lands in bits [31:24]; the word is cleared before each
        // fill so OR-ing keeps unfilled low lanes at zero.
        word <= word | ({bus.rx_data, 24'h000000} >> {lane, 3'b000});
        lane <= lane + 2'd1;
        if (remaining != '0) begin
          remaining <= remaining - LENGTH_WIDTH'(1);
        end
      end
      if (accept) begin
        address_r <= address_r + ADDRESS_WIDTH'(1);
        word      <= '0;
      end
      if (i_stop) begin
        word <= '0;
      end
    end
  end

  assign o_busy      = (state != IDLE);
  assign bus.rx_read = rx_read;
  assign bus.request = request;
  assign bus.write   = request;
  assign bus.bank    = bank_r;
  assign bus.address = address_r;
  assign bus.data    = word;

endmodule

// File: tb/tb_cart_debug_dma.sv
// Self-checking bench for cart_debug_dma: byte-stream model of the FIFO,
// expected-write scoreboard, and a monitor comparing every accepted write.
module tb_cart_debug_dma;
  import cart_pkg::*;

  typedef struct packed {
    logic [3:0]  bank;
    logic [23:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic        i_stop;
  logic [3:0]  i_bank;
  logic [23:0] i_address;
  logic [19:0] i_length;
  logic        o_busy;

  cart_debug_dma_if #(.ADDRESS_WIDTH(24)) dif ();

  cart_debug_dma #(
    .LENGTH_WIDTH (20),
    .ADDRESS_WIDTH(24)
  ) dut (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_start  (i_start),
    .i_stop   (i_stop),
    .i_bank   (i_bank),
    .i_address(i_address),
    .i_length (i_length),
    .o_busy   (o_busy),
    .bus      (dif.master)
  );

  always #5 i_clk = ~i_clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned pops   = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  pkt[$];
  wr_t         exp_q[$];

  int unsigned busy_mode  = 0;   // 0: never busy, 1: busy 3 cycles per write, 2: random
  bit          hold_empty = 1'b0;
  bit          gap_mode   = 1'b0;

  // Values seen at the previous sampling edge.
  logic        s_req = 1'b0, s_busy = 1'b0, s_read = 1'b0, s_stop = 1'b0;
  logic [23:0] p_addr = '0;
  logic [31:0] p_data = '0;
  int unsigned stall = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // FIFO and bus responder model.
  always @(posedge i_clk) begin
    logic [7:0] b;
    if (s_read && (fifo_q.size() > 0)) begin
      b = fifo_q.pop_front();
      dif.rx_data <= b;
    end
    if (s_req && !s_busy) stall = 0;
    else if (s_req) stall++;
    case (busy_mode)
      0:       dif.busy <= 1'b0;
      1:       dif.busy <= (stall < 3);
      default: dif.busy <= ($urandom_range(0, 2) == 0);
    endcase
    dif.rx_empty <= (fifo_q.size() == 0) || hold_empty ||
                    (gap_mode && ($urandom_range(0, 3) == 0));
  end

  // Monitor / scoreboard consumer.
  always @(negedge i_clk) begin
    wr_t e;
    if (i_reset) begin
      s_req = 1'b0; s_busy = 1'b0; s_read = 1'b0; s_stop = 1'b0;
    end else begin
      if (dif.rx_read) begin
        pops++;
        chk("pop_while_empty", 64'(dif.rx_empty), 64'd0);
      end
      if (s_req && s_busy && !s_stop)
        chk("request_held", {7'd0, dif.request, dif.address, dif.data}, {7'd0, 1'b1, p_addr, p_data});
      if (dif.request) begin
        chk("write_qualifier", 64'(dif.write), 64'd1);
        if (!dif.busy) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got 0x%0h@0x%0h expected none", dif.data, dif.address);
          end else begin
            e = exp_q.pop_front();
            chk("write", 64'({dif.bank, dif.address, dif.data}), 64'(e));
          end
        end
      end
      s_req  = dif.request;
      s_busy = dif.busy;
      s_read = dif.rx_read;
      s_stop = i_stop;
      p_addr = dif.address;
      p_data = dif.data;
    end
  end

  // Reference: bytes go out in order, four per word, first byte most
  // significant, short final word zero-padded; words go to addr, addr+1...
  task automatic model(input logic [3:0] b, input logic [23:0] a,
                       input int unsigned nbytes, input int unsigned nwords);
    wr_t w;
    for (int unsigned i = 0; i < nbytes; i++) fifo_q.push_back(pkt[i]);
    for (int unsigned k = 0; k < nwords; k++) begin
      w.bank = b;
      w.addr = a + 24'(k);
      w.data = '0;
      for (int unsigned j = 0; j < 4; j++)
        if (4 * k + j < nbytes) w.data = w.data | (32'(pkt[4 * k + j]) << (24 - 8 * j));
      exp_q.push_back(w);
    end
  endtask

  task automatic do_start(input logic [3:0] b, input logic [23:0] a, input logic [19:0] len);
    @(posedge i_clk); #1;
    i_start = 1'b1; i_bank = b; i_address = a; i_length = len;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_bank = $urandom(); i_address = $urandom(); i_length = $urandom();
  endtask

  task automatic wait_idle(input int unsigned limit);
    int unsigned n = 0;
    do begin @(negedge i_clk); n++; end while (o_busy && n < limit);
    chk("idle_timeout", 64'(o_busy), 64'd0);
  endtask

  task automatic wait_pops(input int unsigned target, input int unsigned limit);
    int unsigned n = 0;
    do begin @(negedge i_clk); n++; end while (pops < target && n < limit);
    chk("pop_timeout", 64'(pops >= target), 64'd1);
  endtask

  task automatic run_xfer(input logic [3:0] b, input logic [23:0] a,
                          input int unsigned len, input bit fixed);
    int unsigned base = pops;
    int unsigned words = (len + 3) / 4;
    logic [23:0] end_a = a + 24'(words);
    if (!fixed) begin
      pkt.delete();
      for (int unsigned i = 0; i < len; i++) pkt.push_back(8'($urandom()));
    end
    model(b, a, len, words);
    do_start(b, a, 20'(len));
    @(negedge i_clk);
    chk("busy_after_start", 64'(o_busy), 64'd1);
    wait_idle(800);
    chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
    chk("pop_count", 64'(pops - base), 64'(len));
    chk("bank_hold", 64'(dif.bank), 64'(b));
    chk("addr_after", 64'(dif.address), 64'(end_a));
  endtask

  function automatic logic [63:0] out_vec();
    return {o_busy, dif.rx_read, dif.request, dif.write, dif.bank, dif.address, dif.data};
  endfunction

  initial begin
    int unsigned base;
    logic [23:0] ra;
    i_reset = 1'b1; i_start = 1'b0; i_stop = 1'b0;
    i_bank = '0; i_address = '0; i_length = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_outputs", out_vec(), 64'd0);
    @(posedge i_clk); #1 i_reset = 1'b0;

    // Basic 8-byte transfer.
    pkt = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_xfer(BANK_SDRAM, 24'hCF8000, 8, 1'b1);

    // Partial final word.
    pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_xfer(BANK_FLASH, 24'h000100, 5, 1'b1);

    // Address wrap with responder busy 3 cycles per write.
    busy_mode = 1;
    run_xfer(BANK_SDRAM, 24'hFFFFFF, 8, 1'b0);
    busy_mode = 0;

    // FIFO runs dry mid-word.
    pkt.delete();
    for (int unsigned i = 0; i < 8; i++) pkt.push_back(8'($urandom()));
    base = pops;
    model(BANK_BRAM, 24'h001230, 8, 2);
    do_start(BANK_BRAM, 24'h001230, 20'd8);
    wait_pops(base + 2, 100);
    @(posedge i_clk); #1 hold_empty = 1'b1;
    @(posedge i_clk);
    repeat (10) begin
      @(negedge i_clk);
      chk("stall_no_pop", 64'(dif.rx_read), 64'd0);
      chk("stall_busy", 64'(o_busy), 64'd1);
    end
    #1 hold_empty = 1'b0;
    wait_idle(200);
    chk("stall_writes", 64'(exp_q.size()), 64'd0);
    chk("stall_pops", 64'(pops - base), 64'd8);

    // Abort after 6 of 16 bytes: only the first full word is written.
    pkt.delete();
    for (int unsigned i = 0; i < 16; i++) pkt.push_back(8'($urandom()));
    base = pops;
    model(BANK_SDRAM, 24'h004000, 16, 1);
    do_start(BANK_SDRAM, 24'h004000, 20'd16);
    wait_pops(base + 6, 100);
    @(posedge i_clk); #1 i_stop = 1'b1;
    @(posedge i_clk); #1 i_stop = 1'b0;
    @(negedge i_clk);
    chk("stop_busy", 64'(o_busy), 64'd0);
    chk("stop_request", 64'(dif.request), 64'd0);
    repeat (5) @(negedge i_clk);
    chk("stop_pops", 64'(pops - base), 64'd6);
    chk("stop_writes", 64'(exp_q.size()), 64'd0);
    chk("stop_addr", 64'(dif.address), 64'h004001);
    fifo_q.delete();
    repeat (2) @(posedge i_clk);
    run_xfer(BANK_SDRAM, 24'h005000, 4, 1'b0);

    // Zero-length start is ignored.
    do_start(BANK_FLASH, 24'h777777, 20'd0);
    @(negedge i_clk);
    chk("len0_busy", 64'(o_busy), 64'd0);
    repeat (5) @(negedge i_clk);
    chk("len0_params", 64'({dif.bank, dif.address}), 64'({BANK_SDRAM, 24'h005001}));

    // Start during a transfer is ignored; simultaneous start+stop too.
    pkt.delete();
    for (int unsigned i = 0; i < 8; i++) pkt.push_back(8'($urandom()));
    base = pops;
    model(BANK_SDRAM, 24'h010000, 8, 2);
    do_start(BANK_SDRAM, 24'h010000, 20'd8);
    repeat (3) @(posedge i_clk);
    do_start(BANK_BRAM, 24'h0ABCDE, 20'd3);
    wait_idle(200);
    chk("restart_writes", 64'(exp_q.size()), 64'd0);
    chk("restart_pops", 64'(pops - base), 64'd8);
    chk("restart_params", 64'({dif.bank, dif.address}), 64'({BANK_SDRAM, 24'h010002}));
    @(posedge i_clk); #1;
    i_start = 1'b1; i_stop = 1'b1; i_bank = BANK_FLASH; i_address = 24'h123456; i_length = 20'd4;
    @(posedge i_clk); #1 i_start = 1'b0; i_stop = 1'b0;
    @(negedge i_clk);
    chk("start_stop_busy", 64'(o_busy), 64'd0);

    // Reset mid-transfer.
    pkt.delete();
    for (int unsigned i = 0; i < 8; i++) pkt.push_back(8'($urandom()));
    base = pops;
    model(BANK_SDRAM, 24'h020000, 8, 2);
    do_start(BANK_SDRAM, 24'h020000, 20'd8);
    wait_pops(base + 3, 100);
    @(posedge i_clk); #1 i_reset = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("midreset_outputs", out_vec(), 64'd0);
    @(posedge i_clk); #1 i_reset = 1'b0;
    exp_q.delete();
    fifo_q.delete();
    repeat (2) @(posedge i_clk);

    // Randomized transfers with random busy and FIFO gaps.
    for (int unsigned t = 0; t < 10; t++) begin
      busy_mode = $urandom_range(0, 2);
      gap_mode  = $urandom_range(0, 1) == 1;
      ra = ($urandom_range(0, 3) == 0) ? 24'hFFFFFE : 24'($urandom());
      run_xfer(4'($urandom()), ra, $urandom_range(1, 13), 1'b0);
    end
    busy_mode = 0;
    gap_mode  = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
